// File: rtl/mode_register.sv
// WIDTH-bit hold/load/count/shift register with terminal-count and zero flags.
// Optional single-level undo via MODE_REGISTER_UNDO_EN.
module mode_register #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             status,
`ifdef MODE_REGISTER_UNDO_EN
  input  logic             undo,
`endif
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;

`ifdef MODE_REGISTER_UNDO_EN
  logic [WIDTH-1:0] shadow;
  logic             upd;

  // Only real operations refresh the shadow, so holds keep undo available.
  assign upd = en && !undo &&
               (mode inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101});
`endif

  always_comb begin
    q_nxt   = q;
    ovf_nxt = 1'b0;
    if (en) begin
      unique case (mode)
        3'b001: q_nxt = d;
        3'b010: begin
          if (q == ONES) begin
            ovf_nxt = 1'b1;
            q_nxt   = SATURATE ? ONES : ZERO;
          end else begin
            q_nxt = q + ONE;
          end
        end
        3'b011: begin
          if (q == ZERO) begin
            ovf_nxt = 1'b1;
            q_nxt   = SATURATE ? ZERO : ONES;
          end else begin
            q_nxt = q - ONE;
          end
        end
        3'b100: q_nxt = {q[WIDTH-2:0], ser_in};
        3'b101: q_nxt = {ser_in, q[WIDTH-1:1]};
        default: q_nxt = q;
      endcase
    end
`ifdef MODE_REGISTER_UNDO_EN
    if (undo) begin
      q_nxt   = shadow;
      ovf_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge status) begin
    if (status) begin
      q    <= RESET_VAL;
      zero <= (RESET_VAL == ZERO);
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      zero <= (q_nxt == ZERO);
      tc   <= (q_nxt == tc_val);
      ovf  <= ovf_nxt;
    end
  end

`ifdef MODE_REGISTER_UNDO_EN
  always_ff @(posedge clk or posedge status) begin
    if (status) begin
      shadow <= RESET_VAL;
    end else if (upd) begin
      shadow <= q;
    end
  end
`endif

endmodule

// File: tb/tb_mode_register.sv
// Randomized bench for mode_register: wrap (RESET_VAL 0) and saturate
// (RESET_VAL 5) instances against a plain arithmetic model.
module tb_mode_register;

  logic       clk = 1'b0;
  logic       status = 1'b1;
  logic       undo = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] d = 4'd0;
  logic       ser_in = 1'b0;
  logic [3:0] tc_val = 4'd0;

  logic [3:0] q0, q1;
  logic       z0, z1, t0, t1, o0, o1;

  int ck = 0;
  int er = 0;

  int mq[2];
  int msh[2];
  bit mz[2];
  bit mt[2];
  bit mo[2];
  int rv[2] = '{0, 5};
  bit sat[2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  mode_register #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .status(status),
`ifdef MODE_REGISTER_UNDO_EN
    .undo(undo),
`endif
    .en(en), .mode(mode), .d(d), .ser_in(ser_in), .tc_val(tc_val),
    .q(q0), .zero(z0), .tc(t0), .ovf(o0)
  );

  mode_register #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) u_sat (
    .clk(clk), .status(status),
`ifdef MODE_REGISTER_UNDO_EN
    .undo(undo),
`endif
    .en(en), .mode(mode), .d(d), .ser_in(ser_in), .tc_val(tc_val),
    .q(q1), .zero(z1), .tc(t1), .ovf(o1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ck++;
    if (got !== exp) begin
      er++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/q0"}, 32'(q0), 32'(mq[0]));
    chk({tag, "/z0"}, 32'(z0), 32'(mz[0]));
    chk({tag, "/t0"}, 32'(t0), 32'(mt[0]));
    chk({tag, "/o0"}, 32'(o0), 32'(mo[0]));
    chk({tag, "/q1"}, 32'(q1), 32'(mq[1]));
    chk({tag, "/z1"}, 32'(z1), 32'(mz[1]));
    chk({tag, "/t1"}, 32'(t1), 32'(mt[1]));
    chk({tag, "/o1"}, 32'(o1), 32'(mo[1]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i]  = rv[i];
      msh[i] = rv[i];
      mz[i]  = (rv[i] == 0);
      mt[i]  = 1'b0;
      mo[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int n;
      bit o;
      n = mq[i];
      o = 1'b0;
      if (undo) begin
        n = msh[i];
      end else if (en) begin
        case (int'(mode))
          1: n = int'(d);
          2: if (mq[i] == 15) begin
               o = 1'b1;
               n = sat[i] ? 15 : 0;
             end else n = mq[i] + 1;
          3: if (mq[i] == 0) begin
               o = 1'b1;
               n = sat[i] ? 0 : 15;
             end else n = mq[i] - 1;
          4: n = (mq[i] * 2 + int'(ser_in)) % 16;
          5: n = mq[i] / 2 + int'(ser_in) * 8;
          default: n = mq[i];
        endcase
        if (mode >= 3'd1 && mode <= 3'd5) msh[i] = mq[i];
      end
      mq[i] = n;
      mz[i] = (n == 0);
      mt[i] = (n == int'(tc_val));
      mo[i] = o;
    end
  endtask

  task automatic cyc(input string tag, input bit e, input logic [2:0] m,
                     input logic [3:0] dd, input bit s,
                     input logic [3:0] tv);
    en = e;
    mode = m;
    d = dd;
    ser_in = s;
    tc_val = tv;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic arst();
    #2 status = 1'b1;
    #1 model_reset();
    check_all("arst");
    #1 status = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    status = 1'b0;

    cyc("ld9", 1, 3'b001, 4'h9, 0, 4'h3);
    chk("q0_is_9", 32'(q0), 32'h9);
    arst();
    chk("arst_q0_zero", 32'(q0), 32'h0);

    cyc("ld0", 1, 3'b001, 4'h0, 0, 4'h3);
    for (int i = 0; i < 16; i++) cyc("up", 1, 3'b010, 4'h0, 0, 4'h3);
    chk("wrap_q0", 32'(q0), 32'h0);
    chk("wrap_ovf0", 32'(o0), 32'h1);
    chk("sat_q1", 32'(q1), 32'hF);

    cyc("ld3", 1, 3'b001, 4'h3, 0, 4'h3);
    chk("tc_at3", 32'(t0), 32'h1);
    cyc("tcmove", 0, 3'b010, 4'h0, 0, 4'h4);
    chk("tc_moved", 32'(t0), 32'h0);

    cyc("ld1", 1, 3'b001, 4'h1, 0, 4'h4);
    for (int i = 0; i < 4; i++) cyc("dn", 1, 3'b011, 4'h0, 0, 4'h4);
    chk("satdn_q1", 32'(q1), 32'h0);
    chk("satdn_ovf1", 32'(o1), 32'h1);

    cyc("ldA", 1, 3'b001, 4'hA, 0, 4'h0);
    cyc("hold", 0, 3'b100, 4'h0, 1, 4'h0);
    cyc("shl", 1, 3'b100, 4'h0, 1, 4'h0);
    chk("shl_q0", 32'(q0), 32'h5);
    cyc("hold", 0, 3'b101, 4'h0, 0, 4'h0);
    cyc("shr", 1, 3'b101, 4'h0, 0, 4'h0);
    chk("shr_q0", 32'(q0), 32'h2);
    cyc("rsv", 1, 3'b110, 4'hF, 1, 4'h2);

`ifdef MODE_REGISTER_UNDO_EN
    cyc("ld7", 1, 3'b001, 4'h7, 0, 4'h0);
    cyc("up8", 1, 3'b010, 4'h0, 0, 4'h0);
    undo = 1'b1;
    cyc("undo1", 1, 3'b010, 4'h0, 0, 4'h0);
    chk("undo_q0", 32'(q0), 32'h7);
    cyc("undo2", 1, 3'b010, 4'h0, 0, 4'h0);
    chk("undo2_q0", 32'(q0), 32'h7);
    undo = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef MODE_REGISTER_UNDO_EN
      undo = ($urandom % 8) == 0;
`endif
      cyc("rnd", ($urandom % 4) != 0, 3'($urandom % 8), 4'($urandom),
          1'($urandom), 4'($urandom % 6));
      if (($urandom % 40) == 0) arst();
    end

    $display("CHECKS %0d ERRORS %0d", ck, er);
    $finish;
  end

endmodule

// File: doc/mode_register.md
Name: mode_register

Overview:
Parametrised successor to the team's 2-bit status-cleared register. It is a WIDTH-bit register with a selectable operating mode: hold, parallel load, count up, count down, shift left and shift right. It also provides a programmable terminal-count compare, a wrap/saturate option, and zero/terminal flags. It sits in the datapath as a general counter/shifter/holding register for the control unit and the test benches.

Parameters:
- WIDTH, 4, data/register width in bits (min 2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- SATURATE, 0, 0 = count wraps around, 1 = count saturates at all-ones (up) or 0 (down).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- status  in  1  reset, asynchronous, active-high; forces all state to reset values immediately.
- en  in  1  operation enable; 0 = hold regardless of mode.
- mode  in  3  000 hold, 001 load, 010 up, 011 down, 100 shl, 101 shr, 11x reserved (hold).
- d  in  WIDTH  parallel load data (mode 001).
- ser_in  in  1  serial fill bit for shifts (LSB for shl, MSB for shr).
- tc_val  in  WIDTH  terminal-count compare value.
- q  out  WIDTH  register contents.
- zero  out  1  registered; q == 0.
- tc  out  1  registered; q == tc_val after the update.
- ovf  out  1  one-cycle pulse; count crossed a boundary (wrapped or saturated).

Behaviour:
- Reset (status=1, async): q=RESET_VAL, zero=(RESET_VAL==0), tc=0, ovf=0. Reset dominates clk/en. Deassertion is taken synchronously at the next edge.
- All operations complete in a single cycle; the new q is visible after the rising edge where en=1.
- Load: q<=d.
- Up: q<=q+1 (mod 2^WIDTH). At all-ones: SATURATE=0 wraps to 0 with ovf=1; SATURATE=1 holds all-ones with ovf=1.
- Down: mirror of up. At 0: wraps to all-ones, or holds 0 when saturating; ovf=1 in either case.
- shl: q<={q[WIDTH-2:0],ser_in}. shr: q<={ser_in,q[WIDTH-1:1]}. ovf=0 for shifts.
- Hold, reserved modes, or en=0: q unchanged, ovf=0.
- zero and tc are computed from the next value of q and registered with it, so they are always consistent with q in the same cycle.
- ovf is high for exactly one cycle. Back-to-back boundary events give consecutive pulses.
- tc_val changed while q is held: tc updates on the next edge (compare is re-evaluated every cycle, en-independent).
- Reset mid-count: q returns to RESET_VAL at once; no ovf is generated.

Optional Feature:
- Macro: MODE_REGISTER_UNDO_EN.
- Defined:
  - Adds input undo (1 bit) and a WIDTH-bit shadow register.
  - Every enabled update copies the old q into shadow.
  - undo=1 (takes priority over en/mode) restores q<=shadow, with flags recomputed and ovf=0.
  - Only one level of undo: shadow is unchanged by an undo, so a second undo is a no-op on q.
  - shadow resets to RESET_VAL.
- Undefined: no undo port or shadow register; behaviour otherwise identical.

Test Plan:
- WIDTH=4: assert status async mid-cycle with q=0x9 -> q=0x0 before the next edge; zero=1, ovf=0.
- mode=010, en=1, 16 cycles from 0 with SATURATE=0 -> q reaches 0xF then 0x0; ovf=1 on that cycle only; zero=1.
- SATURATE=1, mode=011 from 0x1 -> 0x0, then stays 0x0 with ovf=1 each further cycle.
- load d=0xA, then shl ser_in=1 -> 0x5, then shr ser_in=0 -> 0x2; en=0 between steps holds value.
- tc_val=0x3, count up from 0 -> tc=1 exactly when q=0x3; changing tc_val to 0x4 while holding -> tc=0 next edge.
- UNDO_EN: load 0x7, up to 0x8, undo -> q=0x7; second undo -> q stays 0x7.
